// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// Module      : core_pkg
// Description : Shared RV32I decode types, opcode constants and helpers.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package core_pkg;

    typedef enum logic [3:0] {
        i_ADD   = 4'd0,
        i_SUB   = 4'd1,
        i_SLL   = 4'd2,
        i_SLT   = 4'd3,
        i_SLTU  = 4'd4,
        i_XOR   = 4'd5,
        i_SRL   = 4'd6,
        i_SRA   = 4'd7,
        i_OR    = 4'd8,
        i_AND   = 4'd9,
        i_LUI   = 4'd10,
        i_AUIPC = 4'd11
    } alu_op_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        alu_op_t     alu_op;
        logic        is_imm;
        logic [31:0] imm_i;
        logic [31:0] imm_u;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        rd_we;
        logic        illegal;
    } dec_t;

    localparam dec_t c_dec_reset = '{
        alu_op:   i_ADD,
        is_imm:   1'b0,
        imm_i:    32'h0,
        imm_u:    32'h0,
        rs1_addr: 5'd0,
        rs2_addr: 5'd0,
        rd_addr:  5'd0,
        rd_we:    1'b0,
        illegal:  1'b0
    };

    // funct3 -> operation when the base (funct7 = 0) encoding applies
    function automatic alu_op_t base_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  base_op = i_ADD;
            3'b001:  base_op = i_SLL;
            3'b010:  base_op = i_SLT;
            3'b011:  base_op = i_SLTU;
            3'b100:  base_op = i_XOR;
            3'b101:  base_op = i_SRL;
            3'b110:  base_op = i_OR;
            default: base_op = i_AND;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32i_decoder.sv
// ----------------------------------------------------------------------------
// Module      : rv32i_decoder
// Description : Combinational RV32I (OP/OP-IMM/LUI/AUIPC) instruction cracker.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module rv32i_decoder
    import core_pkg::*;
(
    input  logic [31:0] i_instr,
    output dec_t        o_dec
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_upper;
    logic       w_legal;
    logic       w_is_imm;
    logic       w_shamt;
    alu_op_t    w_op;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    assign w_upper  = (w_opcode == OPC_LUI) || (w_opcode == OPC_AUIPC);

    always_comb begin
        w_op     = i_ADD;
        w_legal  = 1'b0;
        w_is_imm = 1'b0;
        w_shamt  = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                if (w_funct7 == 7'b0000000) begin
                    w_legal = 1'b1;
                    w_op    = base_op(w_funct3);
                end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
                    w_legal = 1'b1;
                    w_op    = i_SUB;
                end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101) begin
                    w_legal = 1'b1;
                    w_op    = i_SRA;
                end
            end
            OPC_OP_IMM: begin
                w_is_imm = 1'b1;
                case (w_funct3)
                    3'b001: begin
                        w_shamt = 1'b1;
                        w_op    = i_SLL;
                        w_legal = (w_funct7 == 7'b0000000);
                    end
                    3'b101: begin
                        w_shamt = 1'b1;
                        w_op    = (w_funct7 == 7'b0100000) ? i_SRA : i_SRL;
                        w_legal = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
                    end
                    default: begin
                        w_legal = 1'b1;
                        w_op    = base_op(w_funct3);
                    end
                endcase
            end
            OPC_LUI: begin
                w_legal = 1'b1;
                w_op    = i_LUI;
            end
            OPC_AUIPC: begin
                w_legal = 1'b1;
                w_op    = i_AUIPC;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // Legal shift-immediates expose only the shamt; funct7 is not part of the operand
    assign o_dec.imm_i    = (w_legal && w_shamt) ? {27'd0, i_instr[24:20]}
                                                 : {{20{i_instr[31]}}, i_instr[31:20]};
    assign o_dec.imm_u    = {i_instr[31:12], 12'd0};
    assign o_dec.alu_op   = w_legal ? w_op : i_ADD;
    assign o_dec.is_imm   = w_legal && w_is_imm;
    assign o_dec.rs1_addr = w_upper ? 5'd0 : i_instr[19:15];
    assign o_dec.rs2_addr = w_upper ? 5'd0 : i_instr[24:20];
    assign o_dec.rd_addr  = i_instr[11:7];
    assign o_dec.rd_we    = w_legal && (i_instr[11:7] != 5'd0);
    assign o_dec.illegal  = !w_legal;

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// Module      : decode_stage
// Description : Single-entry RV32I decode pipeline register with valid/ready and flush.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module decode_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc_in,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output alu_op_t     alu_op,
    output logic        is_imm,
    output logic [31:0] imm_i,
    output logic [31:0] imm_u,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic        rd_we,
    output logic [31:0] pc_out,
    output logic        illegal
);

    dec_t        w_dec;
    logic        w_capture;
    dec_t        r_dec;
    logic [31:0] r_pc;
    logic        r_valid;

    rv32i_decoder u_decoder (
        .i_instr (instr),
        .o_dec   (w_dec)
    );

    assign in_ready  = flush || !r_valid || out_ready;
    assign w_capture = in_valid && in_ready && !flush;

    // Flush beats capture beats retire; a retire with a capture keeps valid high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_dec   <= c_dec_reset;
            r_pc    <= RESET_PC;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_dec   <= w_dec;
            r_pc    <= pc_in;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign alu_op    = r_dec.alu_op;
    assign is_imm    = r_dec.is_imm;
    assign imm_i     = r_dec.imm_i;
    assign imm_u     = r_dec.imm_u;
    assign rs1_addr  = r_dec.rs1_addr;
    assign rs2_addr  = r_dec.rs2_addr;
    assign rd_addr   = r_dec.rd_addr;
    assign rd_we     = r_dec.rd_we;
    assign illegal   = r_dec.illegal;
    assign pc_out    = r_pc;

endmodule

`default_nettype wire
